// File: rtl/conv_win_sched_if.sv
// Handshake bundle between the convolution window scheduler and its frame controller / datapath.
// master is the scheduler side; slave is the controller/consumer side.
interface conv_win_sched_if #(
  parameter int AW = 5,
  parameter int CW = 10
);
  logic          start;
  logic          stall;
  logic          win_valid;
  logic [AW-1:0] row_out;
  logic [AW-1:0] col_out;
  logic          last_win;
  logic          busy;
  logic          done;
  logic [CW-1:0] win_cnt;

  modport master (
    input  start, stall,
    output win_valid, row_out, col_out, last_win, busy, done, win_cnt
  );

  modport slave (
    output start, stall,
    input  win_valid, row_out, col_out, last_win, busy, done, win_cnt
  );
endinterface

// File: rtl/conv_win_sched.sv
// 3x3 window scheduler: walks every unpadded window position of a frame in raster order,
// honours writeback stall, then waits out the datapath latency before pulsing done.
module conv_win_sched #(
  parameter int IMG_H    = 32,
  parameter int IMG_W    = 32,
  parameter int AW       = 5,
  parameter int PIPE_LAT = 3,
  parameter int CW       = 10
) (
  input  logic              clk,
  input  logic              rst,
  conv_win_sched_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int            DW       = $clog2(PIPE_LAT + 1) + 1;
  localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 3);
  localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 3);
  localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT);

  state_t        state_r, state_s;
  logic [AW-1:0] row_r, row_s;
  logic [AW-1:0] col_r, col_s;
  logic [DW-1:0] drain_r, drain_s;

  logic          win_valid_r, win_valid_s;
  logic [AW-1:0] row_out_r, row_out_s;
  logic [AW-1:0] col_out_r, col_out_s;
  logic          last_win_r, last_win_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [CW-1:0] win_cnt_r, win_cnt_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, position advance and next values of the registered outputs
  always_comb begin
    state_s     = state_r;
    row_s       = row_r;
    col_s       = col_r;
    drain_s     = drain_r;
    win_valid_s = 1'b0;
    last_win_s  = 1'b0;
    done_s      = 1'b0;
    busy_s      = busy_r;
    row_out_s   = row_out_r;
    col_out_s   = col_out_r;
    win_cnt_s   = win_cnt_r;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s   = RUN;
          row_s     = {AW{1'b0}};
          col_s     = {AW{1'b0}};
          drain_s   = {DW{1'b0}};
          win_cnt_s = {CW{1'b0}};
          busy_s    = 1'b1;
        end else begin
          busy_s    = 1'b0;
        end
      end
      RUN: begin
        busy_s = 1'b1;
        if (!bus.stall) begin
          win_valid_s = 1'b1;
          row_out_s   = row_r;
          col_out_s   = col_r;
          win_cnt_s   = win_cnt_r + CW'(1);
          if ((row_r == ROW_LAST) && (col_r == COL_LAST)) begin
            last_win_s = 1'b1;
            drain_s    = {DW{1'b0}};
            state_s    = DRAIN;
          end else if (col_r == COL_LAST) begin
            col_s = {AW{1'b0}};
            row_s = row_r + AW'(1);
          end else begin
            col_s = col_r + AW'(1);
          end
        end else begin
          win_valid_s = 1'b0;
        end
      end
      DRAIN: begin
        // The datapath cannot be stalled, so stall is not consulted here
        if (drain_r == DRAIN_END) begin
          state_s = DONE;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end else begin
          drain_s = drain_r + DW'(1);
          busy_s  = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Position/drain counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r       <= {AW{1'b0}};
      col_r       <= {AW{1'b0}};
      drain_r     <= {DW{1'b0}};
      win_valid_r <= 1'b0;
      row_out_r   <= {AW{1'b0}};
      col_out_r   <= {AW{1'b0}};
      last_win_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      win_cnt_r   <= {CW{1'b0}};
    end else begin
      row_r       <= row_s;
      col_r       <= col_s;
      drain_r     <= drain_s;
      win_valid_r <= win_valid_s;
      row_out_r   <= row_out_s;
      col_out_r   <= col_out_s;
      last_win_r  <= last_win_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      win_cnt_r   <= win_cnt_s;
    end
  end

  assign bus.win_valid = win_valid_r;
  assign bus.row_out   = row_out_r;
  assign bus.col_out   = col_out_r;
  assign bus.last_win  = last_win_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.win_cnt   = win_cnt_r;

endmodule

// File: tb/tb_conv_win_sched.sv
// Directed bench for conv_win_sched: a 5x5 instance for the detailed scenarios and a
// default 32x32 instance for the full-frame count.
module tb_conv_win_sched;

  localparam int AW  = 5;
  localparam int CW  = 10;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_win_sched_if #(.AW(AW), .CW(CW)) if_s ();
  conv_win_sched_if #(.AW(AW), .CW(CW)) if_l ();

  conv_win_sched #(.IMG_H(5), .IMG_W(5), .AW(AW), .PIPE_LAT(LAT), .CW(CW)) dut_s (
    .clk(clk), .rst(rst), .bus(if_s.master)
  );

  conv_win_sched #(.IMG_H(32), .IMG_W(32), .AW(AW), .PIPE_LAT(LAT), .CW(CW)) dut_l (
    .clk(clk), .rst(rst), .bus(if_l.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic drive(input bit big, input logic st, input logic sl);
    if (big) begin
      if_l.start = st;
      if_l.stall = sl;
    end else begin
      if_s.start = st;
      if_s.stall = sl;
    end
  endtask

  task automatic begin_frame(input bit big);
    drive(big, 1'b1, 1'b0);
    tick();
    drive(big, 1'b0, 1'b0);
  endtask

  // mode 0: plain, 1: stall 3 cycles after 4th issue, 2: stall during drain, 3: stray starts
  task automatic run_frame(input bit big, input int mode, input string tag);
    int  wdim, total, n_win, busy_cyc, done_cnt, last_cyc, done_cyc, gap, stall_left;
    bit  order_ok, last_ok, cnt_ok, hold_ok, st, sl, v, lw, b, d;
    int  r, c, wc;
    wdim = big ? 30 : 3;
    total = big ? 900 : 9;
    n_win = 0; busy_cyc = 0; done_cnt = 0; last_cyc = -1; done_cyc = -1;
    gap = 0; stall_left = 0;
    order_ok = 1'b1; last_ok = 1'b1; cnt_ok = 1'b1; hold_ok = 1'b1;
    for (int cyc = 0; cyc < total + 40; cyc++) begin
      v  = big ? if_l.win_valid : if_s.win_valid;
      lw = big ? if_l.last_win  : if_s.last_win;
      b  = big ? if_l.busy      : if_s.busy;
      d  = big ? if_l.done      : if_s.done;
      r  = int'(big ? if_l.row_out : if_s.row_out);
      c  = int'(big ? if_l.col_out : if_s.col_out);
      wc = int'(big ? if_l.win_cnt : if_s.win_cnt);
      st = 1'b0;
      sl = 1'b0;
      if (b) busy_cyc++;
      if (v) begin
        if (r != n_win / wdim || c != n_win % wdim) order_ok = 1'b0;
        if (lw != (n_win == total - 1)) last_ok = 1'b0;
        if (wc != n_win + 1) cnt_ok = 1'b0;
        if (lw) last_cyc = cyc;
        n_win++;
        if (mode == 1 && n_win == 4) stall_left = 3;
        if (mode == 3 && n_win == 2) st = 1'b1;
      end else begin
        if (lw) last_ok = 1'b0;
        if (mode == 1 && n_win == 4) begin
          gap++;
          if (r != 1 || c != 0) hold_ok = 1'b0;
        end
      end
      if (d) begin
        done_cnt++;
        done_cyc = cyc;
        if (mode == 3) st = 1'b1;
      end
      if (stall_left > 0) begin
        sl = 1'b1;
        stall_left--;
      end
      if (mode == 2 && last_cyc >= 0 && done_cyc < 0) sl = 1'b1;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      drive(big, st, sl);
      tick();
    end
    drive(big, 1'b0, 1'b0);
    check({tag, " windows"}, n_win, total);
    check({tag, " order"}, int'(order_ok), 1);
    check({tag, " last_win"}, int'(last_ok), 1);
    check({tag, " win_cnt step"}, int'(cnt_ok), 1);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " done latency"}, done_cyc - last_cyc, LAT + 1);
    check({tag, " busy cycles"}, busy_cyc, total + LAT + 1 + ((mode == 1) ? 3 : 0));
    check({tag, " final win_cnt"}, int'(big ? if_l.win_cnt : if_s.win_cnt), total);
    check({tag, " final row"}, int'(big ? if_l.row_out : if_s.row_out), wdim - 1);
    check({tag, " final col"}, int'(big ? if_l.col_out : if_s.col_out), wdim - 1);
    check({tag, " idle busy"}, int'(big ? if_l.busy : if_s.busy), 0);
    if (mode == 1) begin
      check({tag, " stall gap"}, gap, 3);
      check({tag, " stall tag hold"}, int'(hold_ok), 1);
    end
  endtask

  initial begin
    int quiet_ok;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    check("rst win_valid", int'(if_s.win_valid), 0);
    check("rst busy", int'(if_s.busy), 0);
    check("rst done", int'(if_s.done), 0);
    check("rst last_win", int'(if_s.last_win), 0);
    check("rst win_cnt", int'(if_s.win_cnt), 0);
    check("rst row", int'(if_s.row_out), 0);
    check("rst col", int'(if_s.col_out), 0);
    rst = 1'b0;
    tick();

    begin_frame(1'b0);
    check("start busy", int'(if_s.busy), 1);
    check("start no issue", int'(if_s.win_valid), 0);
    run_frame(1'b0, 0, "plain");

    begin_frame(1'b0);
    run_frame(1'b0, 1, "stall_run");

    begin_frame(1'b0);
    run_frame(1'b0, 2, "stall_drain");

    begin_frame(1'b0);
    run_frame(1'b0, 3, "stray_start");

    // reset after the fifth window
    begin_frame(1'b0);
    repeat (5) tick();
    check("mid win_valid", int'(if_s.win_valid), 1);
    check("mid win_cnt", int'(if_s.win_cnt), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst busy", int'(if_s.busy), 0);
    check("mrst win_cnt", int'(if_s.win_cnt), 0);
    check("mrst win_valid", int'(if_s.win_valid), 0);
    check("mrst row", int'(if_s.row_out), 0);
    quiet_ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if_s.done || if_s.busy || if_s.win_valid) quiet_ok = 0;
    end
    check("mrst quiet", quiet_ok, 1);
    begin_frame(1'b0);
    run_frame(1'b0, 0, "after_rst");

    // rst and start together
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check("rst+start busy", int'(if_s.busy), 0);
    tick();
    check("rst+start stays idle", int'(if_s.busy), 0);
    check("rst+start no issue", int'(if_s.win_valid), 0);

    begin_frame(1'b1);
    run_frame(1'b1, 0, "full32");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
